mux_nx1_reg_en: RTL

//  Parametrised N-to-1 registered channel multiplexer with enable, valid/ready handshake and packet lock.

---
 rtl/mux_nx1_reg_en_pkg.sv | 18 +
 rtl/mux_nx1_reg_en_reg_slice.sv | 40 ++++
 rtl/mux_nx1_reg_en.sv | 104 ++++++++++
 3 files changed

// File: rtl/mux_nx1_reg_en_pkg.sv
// Shared definitions for the N-to-1 registered channel multiplexer:
// default sizing, FSM state type and the select-width helper.
package mux_nx1_reg_en_pkg;

  localparam int NUM_IN_DEF = 4;
  localparam int WIDTH_DEF  = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } mux_state_e;

  // A one-channel mux would give $clog2 == 0; keep sel at least one bit wide.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_nx1_reg_en_reg_slice.sv
// One-entry output register holding data/last/valid; the slot clears to zero
// when its beat drains without a replacement.
module mux_nx1_reg_en_reg_slice
  import mux_nx1_reg_en_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             valid,
  output logic             slot_free
);

  assign slot_free = !valid || ready;

  // load is only raised by the parent while slot_free is high, so a load
  // always either fills an empty slot or replaces a beat leaving this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      last  <= load_last;
      valid <= 1'b1;
    end else if (valid && ready) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_nx1_reg_en.sv
// N-to-1 registered stream multiplexer with enable and packet lock: the source
// picked on the first beat of a packet is held until its last beat is accepted.
module mux_nx1_reg_en
  import mux_nx1_reg_en_pkg::*;
#(
  parameter  int NUM_IN = NUM_IN_DEF,
  parameter  int WIDTH  = WIDTH_DEF,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    enable,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    locked,
  output logic                    sel_err,
  output mux_state_e              state
);

  localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];

  // Handshake: a beat moves on a channel in any cycle where its valid and
  // ready are both high. in_ready never depends on in_valid, and a producer
  // holds valid/data/last stable until the beat is taken.
  mux_state_e       state_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] active;
  logic             in_range;
  logic             slot_free;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] pick_data;
  logic             pick_last;

  assign active   = (state_q == ST_LOCKED) ? sel_q : sel;
  assign in_range = {1'b0, active} < NUM_IN_W;
  assign grant    = !ARESET && enable && slot_free && in_range;

  always_comb begin
    in_ready  = '0;
    pick_data = '0;
    pick_last = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (active == SEL_W'(i)) begin
        in_ready[i] = grant;
        pick_data   = in_data[i*WIDTH +: WIDTH];
        pick_last   = in_last[i];
      end
    end
  end

  assign accept = |(in_ready & in_valid);

  // While unlocked, active is sel itself, so the range check applies to sel.
  assign sel_err = !ARESET && (state_q == ST_IDLE) && enable && !in_range;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && !pick_last) begin
            state_q <= ST_LOCKED;
            sel_q   <= sel;
          end
        end
        ST_LOCKED: begin
          if (accept && pick_last) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign locked = (state_q == ST_LOCKED);
  assign state  = state_q;

  mux_nx1_reg_en_reg_slice #(
    .WIDTH(WIDTH)
  ) u_out_slice (
    .clk       (ACLK),
    .rst       (ARESET),
    .load      (accept),
    .load_data (pick_data),
    .load_last (pick_last),
    .ready     (out_ready),
    .data      (out_data),
    .last      (out_last),
    .valid     (out_valid),
    .slot_free (slot_free)
  );

endmodule
